// File: rtl/ghost_array_ctrl.sv
// ghost_array_ctrl: multi-ghost movement engine. On each accepted tick it
// sweeps the ghosts one at a time, ranks four candidate headings per ghost,
// probes each against an external wall map (one-cycle read latency) and
// commits the first free step, raising a one-cycle catch pulse when the
// committed position lands within the catch radius of the pacman.
module ghost_array_ctrl #(
  parameter int NUM_GHOSTS = 4,
  parameter int X_W        = 10,
  parameter int Y_W        = 9,
  parameter int STEP       = 1,
  parameter int X_MIN      = 0,
  parameter int X_MAX      = 639,
  parameter int Y_MIN      = 0,
  parameter int Y_MAX      = 479,
  parameter int INIT_X     = 200,
  parameter int INIT_DX    = 40,
  parameter int INIT_Y     = 146,
  parameter int HIT_R      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick,
  input  logic                      frighten,
  input  logic [X_W-1:0]            pac_x,
  input  logic [Y_W-1:0]            pac_y,
  output logic                      wall_req,
  output logic [X_W-1:0]            wall_x,
  output logic [Y_W-1:0]            wall_y,
  input  logic                      wall_hit,
  output logic [NUM_GHOSTS*X_W-1:0] ghost_x,
  output logic [NUM_GHOSTS*Y_W-1:0] ghost_y,
  output logic [NUM_GHOSTS*2-1:0]   ghost_dir,
  output logic                      busy,
  output logic [NUM_GHOSTS-1:0]     caught
);

  // FSM encoding
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PICK   = 3'd1;
  localparam logic [2:0] S_PROBE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;
  localparam logic [2:0] S_NEXT   = 3'd5;

  // Heading encoding; reversing a heading is just flipping bit 0
  localparam logic [1:0] D_RIGHT = 2'd0;
  localparam logic [1:0] D_LEFT  = 2'd1;
  localparam logic [1:0] D_DOWN  = 2'd2;
  localparam logic [1:0] D_UP    = 2'd3;

  localparam int IDX_W = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_GHOSTS - 1);

  // Signed coordinate widths: sign bit plus a guard bit so a step past
  // either edge is represented exactly and never wraps.
  localparam int XS = X_W + 2;
  localparam int YS = Y_W + 2;
  localparam int MW = ((X_W > Y_W) ? X_W : Y_W) + 2;

  localparam logic signed [XS-1:0] STEP_X = XS'(STEP);
  localparam logic signed [YS-1:0] STEP_Y = YS'(STEP);
  localparam logic signed [XS-1:0] XMIN_S = XS'(X_MIN);
  localparam logic signed [XS-1:0] XMAX_S = XS'(X_MAX);
  localparam logic signed [YS-1:0] YMIN_S = YS'(Y_MIN);
  localparam logic signed [YS-1:0] YMAX_S = YS'(Y_MAX);
  localparam logic [MW-1:0]        HIT_M  = MW'(HIT_R);

  function automatic logic [1:0] f_rev(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

  function automatic logic [MW-1:0] f_absdiff(input logic [MW-1:0] a,
                                              input logic [MW-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Control state
  logic [2:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [1:0]       r_k;
  logic             r_busy;
  logic             r_wall_req;
  logic [NUM_GHOSTS-1:0] r_caught;

  // Ghost state
  logic [X_W-1:0] r_gx [NUM_GHOSTS];
  logic [Y_W-1:0] r_gy [NUM_GHOSTS];
  logic [1:0]     r_gd [NUM_GHOSTS];

  // Sweep datapath
  logic [X_W-1:0]  r_px;
  logic [Y_W-1:0]  r_py;
  logic            r_fr;
  logic [3:0][1:0] r_cand;
  logic [X_W-1:0]  r_wall_x;
  logic [Y_W-1:0]  r_wall_y;
  logic            r_probe_ok;
  logic [1:0]      r_pdir;
  logic [X_W-1:0]  r_nx;
  logic [Y_W-1:0]  r_ny;
  logic [1:0]      r_nd;

  logic [X_W-1:0]        w_gx;
  logic [Y_W-1:0]        w_gy;
  logic [1:0]            w_gd;
  logic signed [XS-1:0]  w_dx;
  logic signed [YS-1:0]  w_dy;
  logic [XS-1:0]         w_ax;
  logic [YS-1:0]         w_ay;
  logic                  w_x_major;
  logic [1:0]            w_tx;
  logic [1:0]            w_ty;
  logic [1:0]            w_c0;
  logic [1:0]            w_c1;
  logic [1:0]            w_c2;
  logic [1:0]            w_c3;
  logic [1:0]            w_k_nxt;
  logic [1:0]            w_pdir;
  logic signed [XS-1:0]  w_sx;
  logic signed [YS-1:0]  w_sy;
  logic                  w_ok;
  logic [X_W-1:0]        w_probe_x;
  logic [Y_W-1:0]        w_probe_y;
  logic                  w_free;
  logic                  w_probe_start;
  logic                  w_catch;

  assign w_gx = r_gx[r_idx];
  assign w_gy = r_gy[r_idx];
  assign w_gd = r_gd[r_idx];

  // Candidate ranking for the ghost being processed (used in PICK)
  always_comb begin
    w_dx      = $signed({2'b00, r_px}) - $signed({2'b00, w_gx});
    w_dy      = $signed({2'b00, r_py}) - $signed({2'b00, w_gy});
    w_ax      = w_dx[XS-1] ? XS'(-w_dx) : XS'(w_dx);
    w_ay      = w_dy[YS-1] ? YS'(-w_dy) : YS'(w_dy);
    w_x_major = (MW'(w_ax) >= MW'(w_ay));
    w_tx      = w_dx[XS-1] ? D_LEFT : D_RIGHT;
    w_ty      = w_dy[YS-1] ? D_UP   : D_DOWN;
    w_c0      = w_x_major ? w_tx : w_ty;
    w_c1      = w_x_major ? w_ty : w_tx;
    if (r_fr) begin
      w_c0 = f_rev(w_c0);
      w_c1 = f_rev(w_c1);
    end
    w_c2 = w_gd;
    w_c3 = f_rev(w_gd);
  end

  assign w_k_nxt       = r_k + 2'd1;
  assign w_free        = r_probe_ok & ~wall_hit;
  assign w_probe_start = (r_state == S_PICK) ||
                         ((r_state == S_WAIT) && !w_free && (r_k != 2'd3));
  assign w_pdir        = (r_state == S_PICK) ? w_c0 : r_cand[w_k_nxt];

  // Step address for the next probe, with exact range check
  always_comb begin
    w_sx = $signed({2'b00, w_gx});
    w_sy = $signed({2'b00, w_gy});
    case (w_pdir)
      D_RIGHT: w_sx = $signed({2'b00, w_gx}) + STEP_X;
      D_LEFT:  w_sx = $signed({2'b00, w_gx}) - STEP_X;
      D_DOWN:  w_sy = $signed({2'b00, w_gy}) + STEP_Y;
      default: w_sy = $signed({2'b00, w_gy}) - STEP_Y;
    endcase
    w_ok      = (w_sx >= XMIN_S) && (w_sx <= XMAX_S) &&
                (w_sy >= YMIN_S) && (w_sy <= YMAX_S);
    w_probe_x = w_ok ? w_sx[X_W-1:0] : w_gx;
    w_probe_y = w_ok ? w_sy[Y_W-1:0] : w_gy;
  end

  assign w_catch = (f_absdiff(MW'(r_nx), MW'(r_px)) < HIT_M) &&
                   (f_absdiff(MW'(r_ny), MW'(r_py)) < HIT_M);

  // Sweep sequencer: tick acceptance, probe retries, ghost index, pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_k        <= '0;
      r_busy     <= 1'b0;
      r_wall_req <= 1'b0;
      r_caught   <= '0;
    end else begin
      r_wall_req <= 1'b0;
      r_caught   <= '0;
      case (r_state)
        S_IDLE: begin
          if (tick) begin
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_PICK;
          end
        end
        S_PICK: begin
          r_k        <= '0;
          r_wall_req <= 1'b1;
          r_state    <= S_PROBE;
        end
        S_PROBE: r_state <= S_WAIT;
        S_WAIT: begin
          if (w_free || (r_k == 2'd3)) begin
            r_state <= S_COMMIT;
          end else begin
            r_k        <= w_k_nxt;
            r_wall_req <= 1'b1;
            r_state    <= S_PROBE;
          end
        end
        S_COMMIT: begin
          if (w_catch) r_caught[r_idx] <= 1'b1;
          r_state <= S_NEXT;
        end
        S_NEXT: begin
          if (r_idx == LAST_IDX) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= S_PICK;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Ghost position/heading file: only the indexed ghost changes, on COMMIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_GHOSTS; i++) begin
        r_gx[i] <= X_W'(INIT_X + i * INIT_DX);
        r_gy[i] <= Y_W'(INIT_Y);
        r_gd[i] <= D_RIGHT;
      end
    end else if (r_state == S_COMMIT) begin
      for (int i = 0; i < NUM_GHOSTS; i++) begin
        if (r_idx == IDX_W'(i)) begin
          r_gx[i] <= r_nx;
          r_gy[i] <= r_ny;
          r_gd[i] <= r_nd;
        end
      end
    end
  end

  // Latched sweep inputs, candidate list, probe address and chosen move
  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && tick) begin
      r_px <= pac_x;
      r_py <= pac_y;
      r_fr <= frighten;
    end
    if (r_state == S_PICK) r_cand <= {w_c3, w_c2, w_c1, w_c0};
    if (w_probe_start) begin
      r_wall_x   <= w_probe_x;
      r_wall_y   <= w_probe_y;
      r_probe_ok <= w_ok;
      r_pdir     <= w_pdir;
    end
    if (r_state == S_WAIT) begin
      if (w_free) begin
        r_nx <= r_wall_x;
        r_ny <= r_wall_y;
        r_nd <= r_pdir;
      end else begin
        r_nx <= w_gx;
        r_ny <= w_gy;
        r_nd <= w_gd;
      end
    end
  end

  // Flatten the ghost file onto the packed output buses
  always_comb begin
    ghost_x   = '0;
    ghost_y   = '0;
    ghost_dir = '0;
    for (int i = 0; i < NUM_GHOSTS; i++) begin
      ghost_x[i*X_W +: X_W] = r_gx[i];
      ghost_y[i*Y_W +: Y_W] = r_gy[i];
      ghost_dir[i*2 +: 2]   = r_gd[i];
    end
  end

  assign wall_req = r_wall_req;
  assign wall_x   = r_wall_x;
  assign wall_y   = r_wall_y;
  assign busy     = r_busy;
  assign caught   = r_caught;

endmodule

// File: tb/tb_ghost_array_ctrl.sv
// tb_ghost_array_ctrl: directed bench for ghost_array_ctrl with two ghosts.
// A small wall-map responder answers probes one cycle after wall_req.
module tb_ghost_array_ctrl;

  localparam int NG  = 2;
  localparam int X_W = 10;
  localparam int Y_W = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic              tick;
  logic              frighten;
  logic [X_W-1:0]    pac_x;
  logic [Y_W-1:0]    pac_y;
  logic              wall_req;
  logic [X_W-1:0]    wall_x;
  logic [Y_W-1:0]    wall_y;
  logic              wall_hit;
  logic [NG*X_W-1:0] ghost_x;
  logic [NG*Y_W-1:0] ghost_y;
  logic [NG*2-1:0]   ghost_dir;
  logic              busy;
  logic [NG-1:0]     caught;

  int n_tests = 0;
  int n_fail  = 0;
  int mode    = 0;   // 0 open map, 1 everything is wall, 2 wall only at (200,147)

  ghost_array_ctrl #(.NUM_GHOSTS(NG)) dut (
    .clk(clk), .rst(rst), .tick(tick), .frighten(frighten),
    .pac_x(pac_x), .pac_y(pac_y),
    .wall_req(wall_req), .wall_x(wall_x), .wall_y(wall_y), .wall_hit(wall_hit),
    .ghost_x(ghost_x), .ghost_y(ghost_y), .ghost_dir(ghost_dir),
    .busy(busy), .caught(caught)
  );

  always #5 clk = ~clk;

  function automatic logic is_wall(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    case (mode)
      1:       return 1'b1;
      2:       return (x == 10'd200) && (y == 9'd147);
      default: return 1'b0;
    endcase
  endfunction

  // Wall-map memory: answer is valid the cycle after the request
  always @(posedge clk) begin
    if (rst) wall_hit <= 1'b0;
    else     wall_hit <= wall_req && is_wall(wall_x, wall_y);
  end

  // Free-running monitors: probe count/log, catch pulses, busy cycles
  int wreq_cnt = 0;
  int c0_cnt   = 0;
  int c1_cnt   = 0;
  int busy_cnt = 0;
  logic [X_W-1:0] plog_x [16];
  logic [Y_W-1:0] plog_y [16];

  always @(negedge clk) begin
    if (wall_req) begin
      plog_x[wreq_cnt % 16] <= wall_x;
      plog_y[wreq_cnt % 16] <= wall_y;
      wreq_cnt <= wreq_cnt + 1;
    end
    if (caught[0]) c0_cnt <= c0_cnt + 1;
    if (caught[1]) c1_cnt <= c1_cnt + 1;
    if (busy)      busy_cnt <= busy_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One tick, then count busy cycles until the sweep ends (bounded)
  task automatic sweep(output int cyc);
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 400) begin
      cyc++;
      @(negedge clk);
    end
    #1;
    chk("sweep_ends", {63'd0, busy}, 64'd0);
  endtask

  int cyc;
  int base;
  int c0b;
  int c1b;
  int bb;

  initial begin
    rst = 1'b1; tick = 1'b0; frighten = 1'b0;
    pac_x = 10'd300; pac_y = 9'd146;

    // Reset state
    do_reset();
    #1;
    chk("rst_gx",   ghost_x,   {10'd240, 10'd200});
    chk("rst_gy",   ghost_y,   {9'd146, 9'd146});
    chk("rst_dir",  ghost_dir, 4'd0);
    chk("rst_busy", busy,      1'b0);
    chk("rst_caught", caught,  2'b00);
    chk("rst_wreq", wall_req,  1'b0);

    // Open map toward pacman on the right
    mode = 0; pac_x = 10'd300; pac_y = 9'd146;
    base = wreq_cnt;
    sweep(cyc);
    chk("open_busy_cycles", cyc, 10);
    chk("open_wreq", wreq_cnt - base, 2);
    chk("open_probe0_x", plog_x[base % 16], 10'd201);
    chk("open_probe1_x", plog_x[(base + 1) % 16], 10'd241);
    chk("open_gx",  ghost_x,   {10'd241, 10'd201});
    chk("open_gy",  ghost_y,   {9'd146, 9'd146});
    chk("open_dir", ghost_dir, 4'd0);

    // Frightened: run away from pacman
    do_reset();
    frighten = 1'b1;
    sweep(cyc);
    frighten = 1'b0;
    chk("fr_gx",  ghost_x,   {10'd239, 10'd199});
    chk("fr_gy",  ghost_y,   {9'd146, 9'd146});
    chk("fr_dir", ghost_dir, {2'd1, 2'd1});

    // First candidate of ghost0 blocked at (200,147)
    do_reset();
    mode = 2; pac_x = 10'd210; pac_y = 9'd300;
    base = wreq_cnt;
    sweep(cyc);
    chk("blk1_busy_cycles", cyc, 12);
    chk("blk1_wreq", wreq_cnt - base, 3);
    chk("blk1_probe0_y", plog_y[base % 16], 9'd147);
    chk("blk1_gx",  ghost_x,   {10'd240, 10'd201});
    chk("blk1_gy",  ghost_y,   {9'd147, 9'd146});
    chk("blk1_dir", ghost_dir, {2'd2, 2'd0});

    // Everything blocked: nothing moves, 11 cycles per ghost
    do_reset();
    mode = 1; pac_x = 10'd300; pac_y = 9'd146;
    base = wreq_cnt;
    sweep(cyc);
    chk("allblk_busy_cycles", cyc, 22);
    chk("allblk_wreq", wreq_cnt - base, 8);
    chk("allblk_gx",  ghost_x,   {10'd240, 10'd200});
    chk("allblk_gy",  ghost_y,   {9'd146, 9'd146});
    chk("allblk_dir", ghost_dir, 4'd0);

    // Catch pulse on ghost0 only
    do_reset();
    mode = 0; pac_x = 10'd201; pac_y = 9'd146;
    c0b = c0_cnt; c1b = c1_cnt;
    sweep(cyc);
    repeat (2) @(negedge clk);
    #1;
    chk("catch_g0_pulses", c0_cnt - c0b, 1);
    chk("catch_g1_pulses", c1_cnt - c1b, 0);
    chk("catch_gx", ghost_x, {10'd239, 10'd201});

    // A tick while busy is neither honoured nor queued
    do_reset();
    pac_x = 10'd300; pac_y = 9'd146;
    bb = busy_cnt;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (3) @(negedge clk);
    tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    chk("tickbusy_busy_cycles", busy_cnt - bb, 10);
    chk("tickbusy_gx", ghost_x, {10'd241, 10'd201});
    chk("tickbusy_idle", busy, 1'b0);

    // Asynchronous reset in the middle of a sweep
    do_reset();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_gx0_moved", ghost_x[9:0], 10'd201);
    chk("mid_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_gx",   ghost_x, {10'd240, 10'd200});
    chk("midrst_dir",  ghost_dir, 4'd0);
    chk("midrst_wreq", wall_req, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Walk ghost1 to the X_MAX edge, then probe with every cell walled
    do_reset();
    mode = 0; pac_x = 10'd639; pac_y = 9'd146;
    for (int s = 0; s < 399; s++) sweep(cyc);
    chk("edge_walk_gx", ghost_x, {10'd639, 10'd599});
    mode = 1;
    base = wreq_cnt;
    sweep(cyc);
    chk("edge_busy_cycles", cyc, 22);
    chk("edge_probe_x", plog_x[(base + 4) % 16], 10'd639);
    chk("edge_probe_y", plog_y[(base + 4) % 16], 9'd146);
    chk("edge_gx",  ghost_x,   {10'd639, 10'd599});
    chk("edge_dir", ghost_dir, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
